// File: rtl/basys_input_conditioner_if.sv
// basys_input_conditioner_if
// Board-side switch/button bundle between the BaSys pins and the input
// conditioner. The master side drives the raw pins and the sticky clears.
// The slave side (the conditioner) returns the cleaned levels, pulses and flags.
interface basys_input_conditioner_if;
   logic [7:0] switch_in;
   logic [3:0] btn_in;
   logic [3:0] sticky_clr;
   logic [7:0] switch_out;
   logic [3:0] btn_out;
   logic [3:0] btn_press;
   logic [3:0] btn_sticky;
   logic       btn_irq;

   modport master (
      output switch_in, btn_in, sticky_clr,
      input  switch_out, btn_out, btn_press, btn_sticky, btn_irq
   );

   modport slave (
      input  switch_in, btn_in, sticky_clr,
      output switch_out, btn_out, btn_press, btn_sticky, btn_irq
   );
endinterface

// File: rtl/basys_input_conditioner.sv
// basys_input_conditioner
// Synchronises and debounces 8 toggle switches and 4 push buttons, then
// derives one-cycle press pulses for the buttons.
// Optional feature macro: INPUT_COND_STICKY_EN.
//   - Defined: builds per-button sticky press flags with a synchronous clear
//     and an interrupt request.
//   - Undefined: btn_sticky and btn_irq read 0, and sticky_clr is ignored.
// Channels 0-7 carry switch_in[7:0]. Channels 8-11 carry btn_in[3:0].
module basys_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                      CLK_50MHZ_IN,
   input  logic                      rst,
   basys_input_conditioner_if.slave  cond
);

   localparam int               LP_NCH  = 12;
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [LP_NCH-1:0] w_raw;
   logic [LP_NCH-1:0] r_s1;
   logic [LP_NCH-1:0] r_s2;
   logic [LP_NCH-1:0] w_d;
   logic [3:0]        r_d_prev;
   logic [3:0]        r_press;

   assign w_raw = {cond.btn_in, cond.switch_in};

   // Two-flop synchroniser for every asynchronous pin
   always_ff @(posedge CLK_50MHZ_IN or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end

   for (genvar ch = 0; ch < LP_NCH; ch++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic             r_d;

      // Stability counter: any return to the current level wipes the count
      always_ff @(posedge CLK_50MHZ_IN or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
            r_d   <= 1'b0;
         end else if (r_s2[ch] == r_d) begin
            r_cnt <= '0;
         end else if (r_cnt == LP_LAST) begin
            r_d   <= r_s2[ch];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_d[ch] = r_d;
   end

   // Registered rising-edge detect on the debounced button levels
   always_ff @(posedge CLK_50MHZ_IN or posedge rst) begin
      if (rst) begin
         r_d_prev <= 4'b0000;
         r_press  <= 4'b0000;
      end else begin
         r_d_prev <= w_d[11:8];
         r_press  <= w_d[11:8] & ~r_d_prev;
      end
   end

   assign cond.switch_out = w_d[7:0];
   assign cond.btn_out    = w_d[11:8];
   assign cond.btn_press  = r_press;

`ifdef INPUT_COND_STICKY_EN
   logic [3:0] r_sticky;

   // Sticky press flags; a press on the same cycle as a clear keeps the flag set
   always_ff @(posedge CLK_50MHZ_IN or posedge rst) begin
      if (rst) begin
         r_sticky <= 4'b0000;
      end else begin
         r_sticky <= (r_sticky & ~cond.sticky_clr) | r_press;
      end
   end

   assign cond.btn_sticky = r_sticky;
   assign cond.btn_irq    = |r_sticky;
`else
   logic w_unused;

   assign w_unused        = ^cond.sticky_clr;
   assign cond.btn_sticky = 4'b0000;
   assign cond.btn_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_basys_input_conditioner.sv
// tb_basys_input_conditioner
// Directed test of the input conditioner with DEBOUNCE_CYCLES = 8.
// Sticky expectations follow INPUT_COND_STICKY_EN.
module tb_basys_input_conditioner;

   localparam int LP_DB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;
   logic r_sticky_on;

   basys_input_conditioner_if bus ();

   basys_input_conditioner #(
      .DEBOUNCE_CYCLES (LP_DB),
      .CNT_W           (4)
   ) dut (
      .CLK_50MHZ_IN (clk),
      .rst          (rst),
      .cond         (bus)
   );

   always #5 clk = ~clk;

   // Compares one observed value against its expected value and counts the result
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advances one rising edge and settles 1 ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the sticky value expected for the build in use
   function automatic logic [3:0] stk(input logic [3:0] v);
      return r_sticky_on ? v : 4'b0000;
   endfunction

   initial begin
      int presses;
      logic seen_out;
      logic seen_press;
`ifdef INPUT_COND_STICKY_EN
      r_sticky_on = 1'b1;
`else
      r_sticky_on = 1'b0;
`endif
      bus.switch_in  = 8'h00;
      bus.btn_in     = 4'h0;
      bus.sticky_clr = 4'h0;

      // Reset: hold for 3 cycles, all outputs 0
      rst = 1'b1;
      for (int k = 0; k < 3; k++) step();
      check("rst_sw",    {24'd0, bus.switch_out}, 32'h0);
      check("rst_btn",   {28'd0, bus.btn_out},    32'h0);
      check("rst_press", {28'd0, bus.btn_press},  32'h0);
      check("rst_stk",   {28'd0, bus.btn_sticky}, 32'h0);
      check("rst_irq",   {31'd0, bus.btn_irq},    32'h0);
      rst = 1'b0;
      step();
      check("post_rst_sw", {24'd0, bus.switch_out}, 32'h0);

      // Switch levels: A5 appears exactly 10 edges after the change
      bus.switch_in = 8'hA5;
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("sw_lat_%0d", k), {24'd0, bus.switch_out},
               (k >= LP_DB + 2) ? 32'hA5 : 32'h0);
      end

      // Bounce rejection on button 0
      seen_out   = 1'b0;
      seen_press = 1'b0;
      for (int k = 0; k < 40; k++) begin
         bus.btn_in[0] = ((k % 10) < 5) ? 1'b1 : 1'b0;
         step();
         seen_out   |= bus.btn_out[0];
         seen_press |= bus.btn_press[0];
      end
      bus.btn_in[0] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         seen_out   |= bus.btn_out[0];
         seen_press |= bus.btn_press[0];
      end
      check("bounce_out",   {31'd0, seen_out},   32'h0);
      check("bounce_press", {31'd0, seen_press}, 32'h0);

      // Press pulse on button 2
      bus.btn_in[2] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("b2_out_%0d", k), {31'd0, bus.btn_out[2]},
               (k >= 10) ? 32'h1 : 32'h0);
         check($sformatf("b2_press_%0d", k), {28'd0, bus.btn_press},
               (k == 11) ? 32'h4 : 32'h0);
         check($sformatf("b2_stk_%0d", k), {28'd0, bus.btn_sticky},
               {28'd0, stk((k >= 12) ? 4'b0100 : 4'b0000)});
      end
      // Release: no pulse, level falls 10 edges later
      bus.btn_in[2] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("b2_rel_%0d", k), {31'd0, bus.btn_out[2]},
               (k < 10) ? 32'h1 : 32'h0);
         check($sformatf("b2_rel_press_%0d", k), {28'd0, bus.btn_press}, 32'h0);
      end
      bus.sticky_clr = 4'b0100;
      step();
      bus.sticky_clr = 4'b0000;
      check("b2_clr", {28'd0, bus.btn_sticky}, 32'h0);
      check("b2_clr_irq", {31'd0, bus.btn_irq}, 32'h0);

      // Sticky on button 1
      bus.btn_in[1] = 1'b1;
      for (int k = 0; k < 11; k++) step();
      check("b1_press", {28'd0, bus.btn_press}, 32'h2);
      step();
      check("b1_stk", {28'd0, bus.btn_sticky}, {28'd0, stk(4'b0010)});
      check("b1_irq", {31'd0, bus.btn_irq}, {31'd0, r_sticky_on});
      bus.sticky_clr = 4'b0010;
      step();
      bus.sticky_clr = 4'b0000;
      check("b1_clr", {28'd0, bus.btn_sticky}, 32'h0);
      check("b1_clr_irq", {31'd0, bus.btn_irq}, 32'h0);
      // Set and clear on the same edge: set wins
      bus.btn_in[1] = 1'b0;
      for (int k = 0; k < 12; k++) step();
      check("b1_released", {31'd0, bus.btn_out[1]}, 32'h0);
      bus.btn_in[1] = 1'b1;
      for (int k = 0; k < 11; k++) step();
      check("b1_press2", {28'd0, bus.btn_press}, 32'h2);
      check("b1_stk_before", {28'd0, bus.btn_sticky}, 32'h0);
      bus.sticky_clr = 4'b0010;
      step();
      bus.sticky_clr = 4'b0000;
      check("b1_set_wins", {28'd0, bus.btn_sticky}, {28'd0, stk(4'b0010)});
      step();
      check("b1_set_hold", {28'd0, bus.btn_sticky}, {28'd0, stk(4'b0010)});
      check("b1_set_irq", {31'd0, bus.btn_irq}, {31'd0, r_sticky_on});
      bus.btn_in[1] = 1'b0;
      for (int k = 0; k < 12; k++) step();

      // Reset in the middle of a count on button 3
      bus.btn_in[3] = 1'b1;
      for (int k = 0; k < 6; k++) step();
      rst = 1'b1;
      step();
      check("mid_rst_btn", {28'd0, bus.btn_out},    32'h0);
      check("mid_rst_sw",  {24'd0, bus.switch_out}, 32'h0);
      check("mid_rst_stk", {28'd0, bus.btn_sticky}, 32'h0);
      rst = 1'b0;
      presses = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (bus.btn_press[3]) presses++;
         if (k <= 11) begin
            check($sformatf("b3_out_%0d", k), {31'd0, bus.btn_out[3]},
                  (k >= 10) ? 32'h1 : 32'h0);
         end
      end
      check("b3_press_count", presses, 32'd1);
      check("b3_sw_back", {24'd0, bus.switch_out}, 32'hA5);
      check("b3_stk", {28'd0, bus.btn_sticky}, {28'd0, stk(4'b1000)});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
